// File: rtl/axi_lite_pkg.sv
// ============================================================================
// Module   : axi_lite_pkg
// Brief    : AXI4-Lite response codes and read/write engine state encodings.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package axi_lite_pkg;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_XFER = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

endpackage

`default_nettype wire

// File: rtl/axi_lite_master.sv
// ============================================================================
// Module   : axi_lite_master
// Brief    : AXI4-Lite master with independent read and write engines and
//            client-visible RRESP/BRESP.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_lite_master
  import axi_lite_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  resetn,

  input  logic                  rd_req_valid,
  output logic                  rd_req_ready,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic                  rd_resp_valid,
  output logic [DATA_W-1:0]     rd_resp_data,
  output logic [1:0]            rd_resp_err,

  input  logic                  wr_req_valid,
  output logic                  wr_req_ready,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [DATA_W/8-1:0]   wr_strb,
  output logic                  wr_resp_valid,
  output logic [1:0]            wr_resp_err,

  output logic [ADDR_W-1:0]     M_AXI_ARADDR,
  output logic                  M_AXI_ARVALID,
  input  logic                  M_AXI_ARREADY,
  input  logic [DATA_W-1:0]     M_AXI_RDATA,
  input  logic [1:0]            M_AXI_RRESP,
  input  logic                  M_AXI_RVALID,
  output logic                  M_AXI_RREADY,

  output logic [ADDR_W-1:0]     M_AXI_AWADDR,
  output logic                  M_AXI_AWVALID,
  input  logic                  M_AXI_AWREADY,
  output logic [DATA_W-1:0]     M_AXI_WDATA,
  output logic [DATA_W/8-1:0]   M_AXI_WSTRB,
  output logic                  M_AXI_WVALID,
  input  logic                  M_AXI_WREADY,
  input  logic [1:0]            M_AXI_BRESP,
  input  logic                  M_AXI_BVALID,
  output logic                  M_AXI_BREADY
);

  // --------------------------------------------------------------------------
  // Read engine
  // --------------------------------------------------------------------------
  rd_state_t             r_rd_state;
  logic                  r_rd_ready;
  logic                  r_arvalid;
  logic                  r_rready;
  logic                  r_rd_resp_valid;
  logic [ADDR_W-1:0]     r_araddr;
  logic [DATA_W-1:0]     r_rd_data;
  logic [1:0]            r_rd_err;

  // Ready is registered so that every output is low while reset is held.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rd_state      <= R_IDLE;
      r_rd_ready      <= 1'b0;
      r_arvalid       <= 1'b0;
      r_rready        <= 1'b0;
      r_rd_resp_valid <= 1'b0;
      r_araddr        <= '0;
      r_rd_data       <= '0;
      r_rd_err        <= 2'b00;
    end else begin
      r_rd_resp_valid <= 1'b0;
      case (r_rd_state)
        R_IDLE: begin
          r_rd_ready <= 1'b1;
          if (rd_req_valid && r_rd_ready) begin
            r_araddr   <= rd_addr;
            r_arvalid  <= 1'b1;
            r_rd_ready <= 1'b0;
            r_rd_state <= R_ADDR;
          end
        end
        R_ADDR: begin
          if (M_AXI_ARREADY) begin
            r_arvalid  <= 1'b0;
            r_rready   <= 1'b1;
            r_rd_state <= R_DATA;
          end
        end
        R_DATA: begin
          if (M_AXI_RVALID) begin
            r_rd_data       <= M_AXI_RDATA;
            r_rd_err        <= M_AXI_RRESP;
            r_rd_resp_valid <= 1'b1;
            r_rready        <= 1'b0;
            r_rd_ready      <= 1'b1;
            r_rd_state      <= R_IDLE;
          end
        end
        default: begin
          r_arvalid  <= 1'b0;
          r_rready   <= 1'b0;
          r_rd_ready <= 1'b0;
          r_rd_state <= R_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Write engine
  // --------------------------------------------------------------------------
  wr_state_t             r_wr_state;
  logic                  r_wr_ready;
  logic                  r_awvalid;
  logic                  r_wvalid;
  logic                  r_bready;
  logic                  r_aw_done;
  logic                  r_w_done;
  logic                  r_wr_resp_valid;
  logic [ADDR_W-1:0]     r_awaddr;
  logic [DATA_W-1:0]     r_wdata;
  logic [DATA_W/8-1:0]   r_wstrb;
  logic [1:0]            r_wr_err;

  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_aw_ok;
  logic                  w_w_ok;

  // A channel counts as done if it completed earlier or is completing now.
  assign w_aw_hs = r_awvalid && M_AXI_AWREADY;
  assign w_w_hs  = r_wvalid  && M_AXI_WREADY;
  assign w_aw_ok = r_aw_done || w_aw_hs;
  assign w_w_ok  = r_w_done  || w_w_hs;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_state      <= W_IDLE;
      r_wr_ready      <= 1'b0;
      r_awvalid       <= 1'b0;
      r_wvalid        <= 1'b0;
      r_bready        <= 1'b0;
      r_aw_done       <= 1'b0;
      r_w_done        <= 1'b0;
      r_wr_resp_valid <= 1'b0;
      r_awaddr        <= '0;
      r_wdata         <= '0;
      r_wstrb         <= '0;
      r_wr_err        <= 2'b00;
    end else begin
      r_wr_resp_valid <= 1'b0;
      case (r_wr_state)
        W_IDLE: begin
          r_wr_ready <= 1'b1;
          if (wr_req_valid && r_wr_ready) begin
            r_awaddr   <= wr_addr;
            r_wdata    <= wr_data;
            r_wstrb    <= wr_strb;
            r_awvalid  <= 1'b1;
            r_wvalid   <= 1'b1;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
            r_wr_ready <= 1'b0;
            r_wr_state <= W_XFER;
          end
        end
        W_XFER: begin
          if (w_aw_hs) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (w_w_hs) begin
            r_wvalid <= 1'b0;
            r_w_done <= 1'b1;
          end
          if (w_aw_ok && w_w_ok) begin
            r_bready   <= 1'b1;
            r_wr_state <= W_RESP;
          end
        end
        W_RESP: begin
          if (M_AXI_BVALID) begin
            r_wr_err        <= M_AXI_BRESP;
            r_wr_resp_valid <= 1'b1;
            r_bready        <= 1'b0;
            r_wr_ready      <= 1'b1;
            r_wr_state      <= W_IDLE;
          end
        end
        default: begin
          r_awvalid  <= 1'b0;
          r_wvalid   <= 1'b0;
          r_bready   <= 1'b0;
          r_wr_ready <= 1'b0;
          r_wr_state <= W_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign rd_req_ready  = r_rd_ready;
  assign rd_resp_valid = r_rd_resp_valid;
  assign rd_resp_data  = r_rd_data;
  assign rd_resp_err   = r_rd_err;

  assign wr_req_ready  = r_wr_ready;
  assign wr_resp_valid = r_wr_resp_valid;
  assign wr_resp_err   = r_wr_err;

  assign M_AXI_ARADDR  = r_araddr;
  assign M_AXI_ARVALID = r_arvalid;
  assign M_AXI_RREADY  = r_rready;

  assign M_AXI_AWADDR  = r_awaddr;
  assign M_AXI_AWVALID = r_awvalid;
  assign M_AXI_WDATA   = r_wdata;
  assign M_AXI_WSTRB   = r_wstrb;
  assign M_AXI_WVALID  = r_wvalid;
  assign M_AXI_BREADY  = r_bready;

endmodule

`default_nettype wire

// File: doc/axi_lite_master.md
# axi_lite_master
Parametrised AXI4-Lite master that replaces the single-FSM adapter: read and write channels run as independent concurrent engines, AW and W handshakes complete independently in either order, byte strobes come from the client, and RRESP/BRESP are returned to the client. Sits between internal request logic (DMA/dot-product control) and the AXI-Lite interconnect.
## Interface
- ADDR_W, 32, address width of client and AXI address buses
- DATA_W, 32, data width; legal values 32 or 64; strobe width is DATA_W/8
- clk  input  1  sole clock; all logic on rising edge
- resetn  input  1  asynchronous, active-low reset
- rd_req_valid  input  1  client read request
- rd_req_ready  output  1  read engine idle; request accepted when valid&&ready
- rd_addr  input  ADDR_W  read address, sampled at acceptance
- rd_resp_valid  output  1  one-cycle pulse: read complete
- rd_resp_data  output  DATA_W  captured RDATA, held until next read completes
- rd_resp_err  output  2  captured RRESP, held with rd_resp_data
- wr_req_valid  input  1  client write request
- wr_req_ready  output  1  write engine idle; request accepted when valid&&ready
- wr_addr  input  ADDR_W  write address, sampled at acceptance
- wr_data  input  DATA_W  write data, sampled at acceptance
- wr_strb  input  DATA_W/8  byte strobes, sampled at acceptance
- wr_resp_valid  output  1  one-cycle pulse: write complete
- wr_resp_err  output  2  captured BRESP, held until next write completes
- M_AXI_ARADDR  output  ADDR_W  registered read address
- M_AXI_ARVALID  output  1  read address valid
- M_AXI_ARREADY  input  1  read address ready
- M_AXI_RDATA  input  DATA_W  read data
- M_AXI_RRESP  input  2  read response
- M_AXI_RVALID  input  1  read data valid
- M_AXI_RREADY  output  1  read data ready
- M_AXI_AWADDR  output  ADDR_W  registered write address
- M_AXI_AWVALID  output  1  write address valid
- M_AXI_AWREADY  input  1  write address ready
- M_AXI_WDATA  output  DATA_W  registered write data
- M_AXI_WSTRB  output  DATA_W/8  registered write strobes
- M_AXI_WVALID  output  1  write data valid
- M_AXI_WREADY  input  1  write data ready
- M_AXI_BRESP  input  2  write response
- M_AXI_BVALID  input  1  write response valid
- M_AXI_BREADY  output  1  write response ready
## Operation
- Read FSM R_IDLE -> R_ADDR -> R_DATA -> R_IDLE. R_IDLE: rd_req_ready=1; on accept latch ARADDR, ARVALID<=1, go R_ADDR. R_ADDR: on ARREADY, ARVALID<=0, RREADY<=1, go R_DATA. R_DATA: on RVALID, capture RDATA/RRESP, pulse rd_resp_valid, RREADY<=0, go R_IDLE.
- Write FSM W_IDLE -> W_XFER -> W_RESP -> W_IDLE. W_IDLE: wr_req_ready=1; on accept latch AWADDR/WDATA/WSTRB, AWVALID<=1, WVALID<=1, clear aw_done/w_done, go W_XFER. W_XFER: AWVALID drops the cycle after AWREADY, WVALID the cycle after WREADY, independently; when both handshakes done (same cycle or either order) BREADY<=1, go W_RESP. W_RESP: on BVALID, capture BRESP, pulse wr_resp_valid, BREADY<=0, go W_IDLE.
- Engines fully independent: simultaneous rd/wr accepts in one cycle are legal; no ordering between channels guaranteed. Non-OKAY responses are reported, never retried.
- VALID never drops before its handshake; address/data/strobe registers stable while VALID high.
## Timing
- Reset (async assert, sync release): all outputs 0, both FSMs idle, so rd_req_ready/wr_req_ready rise first cycle after release. Reset mid-transaction aborts immediately; VALID/READY drop asynchronously.
- Zero-wait slave: read accept at cycle 0 -> ARVALID cycles 1, RREADY cycle 2, rd_resp_valid cycle 3, ready again cycle 3 (next accept cycle 3 earliest). Write: AW/W cycle 1, BREADY cycle 2, wr_resp_valid cycle 3.
- rd_resp_valid/wr_resp_valid are single-cycle pulses with no client backpressure; ready stays low from accept until the response pulse cycle.
## Structure
- Package axi_lite_pkg: resp codes OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11; rd_state_t, wr_state_t enums. Single flat module; no sub-module.
## Test plan
- Read 0x0000_0010, slave ARREADY after 2 cycles, RDATA=0xDEAD_BEEF RRESP=OKAY -> rd_resp_valid one pulse, rd_resp_data=0xDEADBEEF, rd_resp_err=00, ARVALID held stable until handshake.
- Write 0x20/0x1234_5678 strb 4'b0011, WREADY 3 cycles before AWREADY -> WVALID drops first, AWVALID later, BREADY only after both; BRESP=SLVERR -> wr_resp_err=10.
- Same-cycle AWREADY&&WREADY -> both valids drop together, BREADY next cycle; same-cycle rd and wr accepts -> both complete, responses independent.
- Back-to-back reads with zero-wait slave -> one transaction per 3 cycles, rd_req_ready low between accept and pulse.
- resetn asserted while ARVALID and AWVALID high -> all outputs 0 immediately, both readys 1 one cycle after release, no response pulse.
